// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared FSM state type and index-width helper for the latched priority encoder
package prio_enc_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic int calc_lw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational N-to-LW priority encoder; search starts at base-1 and wraps down to base
module prio_enc_comb import prio_enc_pkg::*; #(
  parameter int N = 16,
  localparam int LW = calc_lw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] base,
  output logic [LW-1:0] idx,
  output logic          any
);
  function automatic logic [LW-1:0] wrap(input logic [LW-1:0] b, input int k);
    int t;
    t = int'(b) + N - k;
    return LW'((t >= N) ? t - N : t);
  endfunction
  // Walk from lowest to highest priority so the last hit is the winner
  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N; k >= 1; k--)
      if (req[wrap(base, k)]) idx = wrap(base, k);
  end
endmodule

// File: rtl/prio_encoder_latch.sv
// prio_encoder_latch: sticky request capture with held, acknowledged priority grants.
// Build option PRIO_ROTATE_EN selects round-robin search from the last accepted grant.
module prio_encoder_latch import prio_enc_pkg::*; #(
  parameter int N = 16,
  localparam int LW = calc_lw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EI,
  input  logic [N-1:0]  A,
  input  logic          ACK,
  output logic [LW-1:0] L,
  output logic          GS,
  output logic          EO,
  output logic [N-1:0]  PEND
);
  state_t r_state, w_state_nx;
  logic [N-1:0] r_pend, w_pend_nx, w_clr;
  logic [LW-1:0] r_l, w_l_nx, w_idx, w_base;
  logic w_any, w_acc;
  assign w_acc = GS & ACK;
  assign w_clr = w_acc ? (N'(1) << r_l) : '0;
  // A set in the same cycle as the clear wins
  assign w_pend_nx = (r_pend & ~w_clr) | (EI ? A : '0);
`ifdef PRIO_ROTATE_EN
  logic [LW-1:0] r_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (w_acc) r_ptr <= r_l;
  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif
  prio_enc_comb #(.N(N)) u_enc (
    .req  (r_pend),
    .base (w_base),
    .idx  (w_idx),
    .any  (w_any)
  );
  always_comb begin
    w_state_nx = r_state;
    w_l_nx = r_l;
    w_state_nx = (r_state == IDLE) ? ((EI & w_any) ? GRANT : IDLE) : (ACK ? IDLE : GRANT);
    w_l_nx = (r_state == IDLE && EI && w_any) ? w_idx : r_l;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend <= '0;
      r_l <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pend <= w_pend_nx;
      r_l <= w_l_nx;
    end
  assign GS = (r_state == GRANT);
  assign L = r_l;
  assign PEND = r_pend;
  assign EO = EI & ~|r_pend & ~GS;
endmodule

// File: tb/tb_prio_encoder_latch.sv
// tb_prio_encoder_latch: directed vector table plus hand sequences for the latched priority encoder
module tb_prio_encoder_latch;
  logic clk = 1'b0, rst_n = 1'b0, EI = 1'b0, ACK = 1'b0, GS, EO;
  logic [15:0] A = '0, PEND;
  logic [3:0] L;
  int errors = 0, checks = 0;

  typedef struct {
    logic [15:0] a;
    logic ei;
    logic ack;
    logic gs;
    logic [3:0] l;
    logic [15:0] pend;
  } vec_t;
  vec_t tbl[$];

  prio_encoder_latch #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .EI(EI), .A(A), .ACK(ACK),
    .L(L), .GS(GS), .EO(EO), .PEND(PEND)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] a, input logic ei, input logic ack,
                     input logic gs, input logic [3:0] l, input logic [15:0] pend);
    vec_t v;
    v.a = a; v.ei = ei; v.ack = ack; v.gs = gs; v.l = l; v.pend = pend;
    tbl.push_back(v);
  endtask

  task automatic do_reset;
    A = '0; EI = 1'b0; ACK = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  function automatic logic [3:0] rot_exp(input int i, input logic [15:0] req);
`ifdef PRIO_ROTATE_EN
    return (req == 16'hFFFF) ? 4'(15 - (i % 16)) : ((i % 2 == 0) ? 4'd15 : 4'd0);
`else
    return (req != 16'h0) ? 4'd15 : 4'd0;
`endif
  endfunction

  task automatic held_run(input string name, input logic [15:0] req, input int n);
    A = req; EI = 1'b1; ACK = 1'b0;
    tick;
    chk({name, "_pend"}, 32'(PEND), 32'(req));
    for (int i = 0; i < n; i++) begin
      tick;
      chk({name, "_gs"}, 32'(GS), 32'(1));
      chk({name, "_l"}, 32'(L), 32'(rot_exp(i, req)));
      ACK = 1'b1;
      tick;
      chk({name, "_gs_off"}, 32'(GS), 32'(0));
      ACK = 1'b0;
    end
  endtask

  initial begin
    // walking one: pulse, grant, ack
    for (int k = 0; k < 16; k++) begin
      add(16'(1 << k), 1, 0, 0, 4'(k), 16'(1 << k));
      add(16'h0, 1, 0, 1, 4'(k), 16'(1 << k));
      add(16'h0, 1, 1, 0, 4'(k), 16'h0);
    end
    // priority and hold without preemption
    add(16'h0024, 1, 0, 0, 4'd0, 16'h0024);
    add(16'h0000, 1, 0, 1, 4'd5, 16'h0024);
    add(16'h8000, 1, 0, 1, 4'd5, 16'h8024);
    add(16'h0000, 1, 1, 0, 4'd5, 16'h8004);
    add(16'h0000, 1, 0, 1, 4'd15, 16'h8004);
    add(16'h0000, 1, 1, 0, 4'd15, 16'h0004);
    add(16'h0000, 1, 0, 1, 4'd2, 16'h0004);
    add(16'h0000, 1, 1, 0, 4'd2, 16'h0000);
    add(16'h0000, 1, 0, 0, 4'd2, 16'h0000);
    // clear/set collision keeps the bit pending
    add(16'h0008, 1, 0, 0, 4'd0, 16'h0008);
    add(16'h0000, 1, 0, 1, 4'd3, 16'h0008);
    add(16'h0008, 1, 1, 0, 4'd3, 16'h0008);
    add(16'h0000, 1, 0, 1, 4'd3, 16'h0008);
    add(16'h0000, 1, 1, 0, 4'd3, 16'h0000);
    // ACK while idle is ignored
    add(16'h0000, 1, 1, 0, 4'd0, 16'h0000);
    // EI drop mid-grant
    add(16'h0082, 1, 0, 0, 4'd0, 16'h0082);
    add(16'h0000, 1, 0, 1, 4'd7, 16'h0082);
    add(16'h0100, 0, 0, 1, 4'd7, 16'h0082);
    add(16'h0000, 0, 1, 0, 4'd7, 16'h0002);
    add(16'h0000, 0, 0, 0, 4'd7, 16'h0002);
    add(16'h0000, 1, 0, 1, 4'd1, 16'h0002);
    add(16'h0000, 1, 1, 0, 4'd1, 16'h0000);

    // reset and EI gating
    EI = 1'b0; A = 16'h8001; rst_n = 1'b0;
    tick;
    chk("rst_gs", 32'(GS), 32'(0));
    chk("rst_pend", 32'(PEND), 32'(0));
    chk("rst_l", 32'(L), 32'(0));
    chk("rst_eo", 32'(EO), 32'(0));
    rst_n = 1'b1;
    tick;
    chk("ei0_pend", 32'(PEND), 32'(0));
    chk("ei0_gs", 32'(GS), 32'(0));
    chk("ei0_eo", 32'(EO), 32'(0));
    A = '0; EI = 1'b1;
    #1;
    chk("ei1_eo", 32'(EO), 32'(1));
    tick;

    foreach (tbl[i]) begin
      A = tbl[i].a; EI = tbl[i].ei; ACK = tbl[i].ack;
      tick;
      chk($sformatf("v%0d_gs", i), 32'(GS), 32'(tbl[i].gs));
      chk($sformatf("v%0d_pend", i), 32'(PEND), 32'(tbl[i].pend));
      chk($sformatf("v%0d_eo", i), 32'(EO),
          32'(tbl[i].ei & (tbl[i].pend == 16'h0) & ~tbl[i].gs));
      if (tbl[i].gs) chk($sformatf("v%0d_l", i), 32'(L), 32'(tbl[i].l));
    end

    // reset mid-grant drops grant and pending bits asynchronously
    A = 16'h0410; EI = 1'b1; ACK = 1'b0;
    tick;
    A = '0;
    tick;
    chk("mid_gs_pre", 32'(GS), 32'(1));
    chk("mid_l_pre", 32'(L), 32'(10));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_gs", 32'(GS), 32'(0));
    chk("mid_pend", 32'(PEND), 32'(0));
    chk("mid_l", 32'(L), 32'(0));
    tick;
    rst_n = 1'b1;
    tick;

    do_reset;
    held_run("all1", 16'hFFFF, 17);
    do_reset;
    held_run("pair", 16'h8001, 4);
    do_reset;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prio_encoder_latch.md
Name: prio_encoder_latch

Overview:
- Parametrised, registered successor to the combinational 16-to-4 priority encoder (EI/EO/GS/A/L interface).
- Captures request pulses on A into a sticky pending register and presents the highest-priority pending index on L with GS as valid.
- Holds each grant until the consumer acknowledges it; ACK clears that pending bit.
- Used as an event/interrupt encoder between request sources and a single sequential consumer; EO supports cascading encoders.

Parameters:
- N, 16, number of request inputs (N >= 2).
- LW, $clog2(N), width of L; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- EI  in  1  enable: gates request capture and new grants.
- A  in  N  request vector; any bit high at a clock edge sets that pending bit.
- ACK  in  1  consumer accepts the presented grant.
- L  out  LW  granted index, binary.
- GS  out  1  grant valid.
- EO  out  1  enable-out for cascading: EI & (pend == 0) & ~GS.
- PEND  out  N  current pending register.

Behaviour:
- Reset (asynchronous assert, synchronous release): pend=0, L=0, GS=0, FSM=IDLE. EO then follows EI. Reset mid-grant drops the grant and all pending bits.
- Capture: at each edge, pend <= (pend & ~clr) | (EI ? A : 0).
  - clr = onehot(L) when GS & ACK, else 0.
  - If a bit is cleared and re-requested in the same cycle, the set wins and the bit stays pending.
- Priority: highest index wins (A[N-1] highest, A[0] lowest) in fixed mode.
- FSM states: IDLE and GRANT.
  - IDLE, EI=1 and pend!=0: L <= enc(pend), GS <= 1, go to GRANT.
  - IDLE, otherwise: GS=0, L holds its last value.
  - GRANT, ACK=0: L and GS stay stable. There is no preemption by higher requests, and EI=0 does not revoke the grant.
  - GRANT, ACK=1: GS <= 0, the granted bit is cleared, go to IDLE.
- Latency:
  - Request on A at edge t sets pend at t; GS/L are valid after edge t+1.
  - ACK at edge t gives GS=0 after t. The next grant is possible after t+1.
  - Maximum rate is one grant per 2 cycles.
- ACK while GS=0 is ignored (no clear, no state change).
- EI=0:
  - A is ignored.
  - pend is retained and visible on PEND.
  - No new grant is issued.
  - A grant already in progress still completes on ACK.
- All-ones A: grants are issued in descending index order, one per handshake.
- Width rule: L is zero-extended binary index. For N not a power of two, indices >= N never occur.

Optional Feature:
- Macro: PRIO_ROTATE_EN.
- Defined (round-robin):
  - A last-grant pointer `ptr` (LW bits) resets to 0.
  - Search order is ptr-1, ptr-2, ... wrapping modulo N, ending at ptr. From reset, N-1 is highest.
  - ptr <= L on each accepted grant (GS & ACK).
  - A continuously requesting source cannot starve the others.
- Undefined: fixed highest-index priority; `ptr` and its logic are absent.
- Ports and timing are identical in both builds.

Decomposition:
- Package prio_enc_pkg: state enum {IDLE, GRANT}; a function for the clog2-based LW computation.
- Sub-module prio_enc_comb: purely combinational N-to-LW encoder.
  - Inputs: req, base.
  - Outputs: idx, any.
  - base is tied to 0 in fixed mode and driven by ptr in rotate mode.
  - The top level holds the pending register, FSM, output registers and EO.

Test Plan:
- Reset/EI: rst_n=0, then 1 with EI=0, A=16'h8001 -> GS=0, PEND=0, EO=0. Then EI=1 -> EO=1.
- Walking one: EI=1, A=1<<k for k=0..15, one-cycle pulses, each ACKed -> L=k and GS=1 two edges after each pulse.
- Priority and hold:
  - A=16'h0024 pulse -> L=5.
  - While holding without ACK, pulse A=16'h8000 -> L stays 5.
  - ACK -> next grants L=15, then L=2, then GS=0 with PEND=0.
- Clear/set collision: grant L=3 and pulse A[3] in the same cycle as ACK -> PEND[3] stays 1 and L=3 is re-granted.
- EI drop mid-grant: L=7 granted, EI=0, pulse A=16'h0100 -> capture ignored. ACK clears bit 7, and no new grant is issued until EI=1.
- PRIO_ROTATE_EN: hold A=16'hFFFF -> L sequence 15,14,...,0,15. Then hold A=16'h8001 continuously -> L alternates 15,0.
